// File: rtl/matrix_4x4_pkg.sv
// matrix_4x4_pkg: shared constants, loader state type and frame index decoder
package matrix_4x4_pkg;
    localparam int MAT_N = 4;
    localparam int FRAME_WORDS = 32;

    typedef enum logic [1:0] {FILL, HOLD, DRAIN} ldr_state_t;

    typedef struct packed {
        logic       mat;
        logic [1:0] col;
        logic [1:0] row;
    } elem_pos_t;

    function automatic elem_pos_t idx_pos(input logic [4:0] idx);
        return '{mat: idx[4], col: idx[3:2], row: idx[1:0]};
    endfunction
endpackage

// File: rtl/matrix_4x4_loader.sv
// matrix_4x4_loader: assembles a 32-word stream into A/B column operands held until accepted
//   s_valid/s_ready/s_data/s_last : input word stream, s_last closes a frame
//   valid_out/ready_in            : operand handshake towards the compute block
//   aC1..aC4, bC1..bC4            : operand columns, index r = row r
//   frame_err                     : one-cycle pulse on a bad frame length
module matrix_4x4_loader
    import matrix_4x4_pkg::*;
#(
    parameter int W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [W-1:0]        s_data,
    input  logic                s_last,
    output logic                valid_out,
    input  logic                ready_in,
    output logic [3:0][W-1:0]   aC1,
    output logic [3:0][W-1:0]   aC2,
    output logic [3:0][W-1:0]   aC3,
    output logic [3:0][W-1:0]   aC4,
    output logic [3:0][W-1:0]   bC1,
    output logic [3:0][W-1:0]   bC2,
    output logic [3:0][W-1:0]   bC3,
    output logic [3:0][W-1:0]   bC4,
    output logic                frame_err
);
    ldr_state_t state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic       s_ready_q, s_ready_d;
    logic       valid_out_q, valid_out_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0][MAT_N-1:0][MAT_N-1:0][W-1:0] mem_q, mem_d;
    elem_pos_t  pos;
    logic       accept;
    logic       last_idx;

    always_comb begin
        pos = idx_pos(idx_q);
        accept = s_valid && s_ready_q;
        last_idx = idx_q == 5'(FRAME_WORDS - 1);
        state_d = state_q;
        idx_d = idx_q;
        mem_d = mem_q;
        frame_err_d = 1'b0;
        case (state_q)
            FILL: if (accept) begin
                mem_d[pos.mat][pos.col][pos.row] = s_data;
                idx_d = (last_idx || s_last) ? '0 : idx_q + 5'd1;
                // s_last must coincide with word 31: early last or missing last are both errors
                frame_err_d = last_idx != s_last;
                if (last_idx) state_d = s_last ? HOLD : DRAIN;
            end
            HOLD: if (ready_in) begin
                state_d = FILL;
                idx_d = '0;
            end
            DRAIN: if (accept && s_last) begin
                state_d = FILL;
                idx_d = '0;
            end
            default: begin
                state_d = FILL;
                idx_d = '0;
            end
        endcase
        // handshake outputs registered from next state, so no input-to-output path
        s_ready_d = state_d != HOLD;
        valid_out_d = state_d == HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            idx_q <= '0;
            s_ready_q <= 1'b0;
            valid_out_q <= 1'b0;
            frame_err_q <= 1'b0;
            mem_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            s_ready_q <= s_ready_d;
            valid_out_q <= valid_out_d;
            frame_err_q <= frame_err_d;
            mem_q <= mem_d;
        end
    end

    assign s_ready = s_ready_q;
    assign valid_out = valid_out_q;
    assign frame_err = frame_err_q;
    assign aC1 = mem_q[0][0];
    assign aC2 = mem_q[0][1];
    assign aC3 = mem_q[0][2];
    assign aC4 = mem_q[0][3];
    assign bC1 = mem_q[1][0];
    assign bC2 = mem_q[1][1];
    assign bC3 = mem_q[1][2];
    assign bC4 = mem_q[1][3];
endmodule

// File: tb/tb_matrix_4x4_loader.sv
// tb_matrix_4x4_loader: directed self-checking bench for the stream-to-matrix loader
module tb_matrix_4x4_loader;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_valid = 1'b0;
    logic s_last = 1'b0;
    logic ready_in = 1'b0;
    logic [W-1:0] s_data = '0;
    logic s_ready, valid_out, frame_err;
    logic [3:0][W-1:0] aC1, aC2, aC3, aC4, bC1, bC2, bC3, bC4;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    matrix_4x4_loader #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .valid_out(valid_out), .ready_in(ready_in),
        .aC1(aC1), .aC2(aC2), .aC3(aC3), .aC4(aC4),
        .bC1(bC1), .bC2(bC2), .bC3(bC3), .bC4(bC4),
        .frame_err(frame_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] col(input int v0);
        return {12'(v0 + 3), 12'(v0 + 2), 12'(v0 + 1), 12'(v0)};
    endfunction

    task automatic chk_frame(input string tag, input int base);
        chk({tag, "_aC1"}, aC1, col(base));
        chk({tag, "_aC2"}, aC2, col(base + 4));
        chk({tag, "_aC3"}, aC3, col(base + 8));
        chk({tag, "_aC4"}, aC4, col(base + 12));
        chk({tag, "_bC1"}, bC1, col(base + 16));
        chk({tag, "_bC2"}, bC2, col(base + 20));
        chk({tag, "_bC3"}, bC3, col(base + 24));
        chk({tag, "_bC4"}, bC4, col(base + 28));
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 64'(n < 50), 64'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int k = 0; k < 32; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                ready_in = 1'($urandom_range(0, 1));
            end
            if (k == 31) begin
                ready_in = 1'b0;
                chk("no_early_valid", valid_out, 0);
            end
            send_word(W'(base + k), k == 31);
        end
    endtask

    task automatic handshake;
        @(negedge clk);
        chk("hs_pre_valid", valid_out, 1);
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
        chk("hs_valid", valid_out, 0);
        chk("hs_ready", s_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_valid", valid_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", s_ready, 1);
        chk("post_rst_valid", valid_out, 0);
        chk("post_rst_ferr", frame_err, 0);
        chk("post_rst_aC1", aC1, 0);
        chk("post_rst_bC4", bC4, 0);

        send_frame(1, 0);
        @(negedge clk);
        chk("f1_valid", valid_out, 1);
        chk("f1_ready", s_ready, 0);
        chk("f1_ferr", frame_err, 0);
        chk("f1_aC1_lit", aC1, 48'h004_003_002_001);
        chk("f1_bC4_3", bC4[3], 32);
        chk_frame("f1", 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data = W'($urandom);
            chk("hold_valid", valid_out, 1);
            chk("hold_ready", s_ready, 0);
            chk_frame("hold", 1);
        end
        s_valid = 1'b0;
        handshake();

        send_frame(1, 1);
        @(negedge clk);
        chk("f2_valid", valid_out, 1);
        chk_frame("f2", 1);
        handshake();

        for (int k = 0; k < 11; k++) send_word(W'(12'h700 + k), k == 10);
        @(negedge clk);
        chk("early_ferr", frame_err, 1);
        chk("early_valid", valid_out, 0);
        chk("early_ready", s_ready, 1);
        @(negedge clk);
        chk("early_ferr_pulse", frame_err, 0);
        send_frame(1, 0);
        @(negedge clk);
        chk("f3_valid", valid_out, 1);
        chk_frame("f3", 1);
        handshake();

        for (int k = 0; k < 32; k++) send_word(W'(12'h200 + k), 1'b0);
        @(negedge clk);
        chk("miss_ferr", frame_err, 1);
        chk("miss_valid", valid_out, 0);
        chk("miss_ready", s_ready, 1);
        @(negedge clk);
        chk("miss_ferr_pulse", frame_err, 0);
        for (int k = 0; k < 5; k++) send_word(W'(12'h300 + k), k == 4);
        @(negedge clk);
        chk("drain_valid", valid_out, 0);
        chk("drain_ready", s_ready, 1);
        chk("drain_ferr", frame_err, 0);
        send_frame(1, 0);
        @(negedge clk);
        chk("f4_valid", valid_out, 1);
        chk_frame("f4", 1);
        handshake();

        for (int k = 0; k < 5; k++) send_word(W'(12'h500 + k), 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", s_ready, 0);
        chk("midrst_valid", valid_out, 0);
        chk("midrst_aC1", aC1, 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(1, 0);
        @(negedge clk);
        chk("f5_valid", valid_out, 1);
        chk_frame("f5", 1);

        #2 rst = 1'b1;
        #1;
        chk("holdrst_valid", valid_out, 0);
        chk("holdrst_ready", s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("holdrst_after_ready", s_ready, 1);
        chk("holdrst_after_bC4", bC4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
